// File: rtl/sp_dmem_arbiter.sv
// rtl/sp_dmem_arbiter.sv - two-port arbiter in front of a single-port data memory
`timescale 1ns/1ps

module sp_dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // wait counter must hold MAX_WAIT; latency counter holds MEM_LAT (1..4)
  localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int LCW = 3;

  typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WCW-1:0]      r_wcnt;
  logic [LCW-1:0]      r_lcnt;
  logic                r_rport;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_any_gnt;
  logic                w_gnt_we;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [DATA_W-1:0]   w_gnt_wdata;
  logic                w_rd_done;

  // winner's command fields; port 1 only when it holds the grant
  assign w_any_gnt   = w_gnt0 | w_gnt1;
  assign w_gnt_we    = w_gnt1 ? we1    : we0;
  assign w_gnt_addr  = w_gnt1 ? addr1  : addr0;
  assign w_gnt_wdata = w_gnt1 ? wdata1 : wdata0;
  // last RD_WAIT cycle: memory data is valid now and is captured at this edge
  assign w_rd_done   = (r_state == ST_RD_WAIT) && (r_lcnt == LCW'(MEM_LAT));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state: enter RD_WAIT on a read grant, leave once data is captured
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_any_gnt && !w_gnt_we) w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (w_rd_done)              w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // grant decode: port 0 wins unless port 1 has waited MAX_WAIT cycles
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst && r_state == ST_IDLE) begin
      if (req0 && req1) begin
        if (r_wcnt == WCW'(MAX_WAIT)) w_gnt1 = 1'b1;
        else                          w_gnt0 = 1'b1;
      end else if (req0) begin
        w_gnt0 = 1'b1;
      end else if (req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  // memory command register: strobe for one cycle after each grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_any_gnt;
      if (w_any_gnt) begin
        r_mem_we    <= w_gnt_we;
        r_mem_addr  <= w_gnt_addr;
        r_mem_wdata <= w_gnt_wdata;
      end
    end
  end

  // read latency counter and owner of the outstanding read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lcnt  <= '0;
      r_rport <= 1'b0;
    end else if (w_any_gnt && !w_gnt_we) begin
      r_lcnt  <= '0;
      r_rport <= w_gnt1;
    end else if (r_state == ST_RD_WAIT && !w_rd_done) begin
      r_lcnt  <= r_lcnt + 1'b1;
    end
  end

  // read return: one-cycle rvalid pulse, rdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_rd_done && !r_rport;
      r_rvalid1 <= w_rd_done &&  r_rport;
      if (w_rd_done && !r_rport) r_rdata0 <= mem_rdata;
      if (w_rd_done &&  r_rport) r_rdata1 <= mem_rdata;
    end
  end

  // port-1 starvation counter, also runs while a read is outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (!req1 || w_gnt1) begin
      r_wcnt <= '0;
    end else if (r_wcnt != WCW'(MAX_WAIT)) begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state == ST_RD_WAIT);

endmodule

// File: tb/tb_sp_dmem_arbiter.sv
// tb/tb_sp_dmem_arbiter.sv - self-checking bench for sp_dmem_arbiter
`timescale 1ns/1ps

module tb_sp_dmem_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LAT = 1;
  localparam int MW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sp_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  // Physical memory: write on the command edge, read data valid LAT (=1) cycle later, junk otherwise
  logic [31:0] phys [int];
  always @(posedge clk) begin
    if (mem_en && mem_we) phys[int'(mem_addr)] = mem_wdata;
    if (mem_en && !mem_we)
      mem_rdata <= phys.exists(int'(mem_addr)) ? phys[int'(mem_addr)] : init_val(int'(mem_addr));
    else
      mem_rdata <= $urandom;
  end

  // Reference model: cycle-numbered transactions, checked every cycle at the falling edge
  typedef struct { int at; bit port; logic [31:0] data; } rv_t;
  rv_t         rvq [$];
  logic [31:0] mdl_mem [int];
  int          cyc = 0, ready_at = 0, wcnt_m = 0;
  bit          cmd_en_m = 0, cmd_we_m = 0;
  logic [31:0] cmd_addr_m = '0, cmd_wdata_m = '0;
  logic [31:0] last_rd0 = '0, last_rd1 = '0;

  always @(negedge clk) begin
    bit          eg0, eg1, ebusy, erv0, erv1;
    int          a;
    logic [31:0] d;
    if (rst) begin
      check32("rst_ctl", {25'b0, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy}, 32'h0);
      check32("rst_mem_addr", 32'(mem_addr), 32'h0);
      check32("rst_mem_wdata", mem_wdata, 32'h0);
      check32("rst_rdata0", rdata0, 32'h0);
      check32("rst_rdata1", rdata1, 32'h0);
      rvq.delete();
      ready_at = 0; wcnt_m = 0; cmd_en_m = 0;
      last_rd0 = '0; last_rd1 = '0;
    end else begin
      ebusy = (cyc < ready_at);
      eg0 = 0; eg1 = 0;
      if (!ebusy) begin
        if (req0 && req1) begin
          if (wcnt_m >= MW) eg1 = 1; else eg0 = 1;
        end else if (req0) eg0 = 1;
        else if (req1) eg1 = 1;
      end
      check1("m_gnt0", gnt0, eg0);
      check1("m_gnt1", gnt1, eg1);
      check1("m_busy", busy, ebusy);
      check1("m_mem_en", mem_en, cmd_en_m);
      if (cmd_en_m) begin
        check1("m_mem_we", mem_we, cmd_we_m);
        check32("m_mem_addr", 32'(mem_addr), cmd_addr_m);
        check32("m_mem_wdata", mem_wdata, cmd_wdata_m);
      end
      erv0 = 0; erv1 = 0;
      if (rvq.size() > 0 && rvq[0].at == cyc) begin
        if (rvq[0].port) begin erv1 = 1; last_rd1 = rvq[0].data; end
        else             begin erv0 = 1; last_rd0 = rvq[0].data; end
        void'(rvq.pop_front());
      end
      check1("m_rvalid0", rvalid0, erv0);
      check1("m_rvalid1", rvalid1, erv1);
      check32("m_rdata0", rdata0, last_rd0);
      check32("m_rdata1", rdata1, last_rd1);
      // port 1 waits count consecutive denied cycles
      if (req1 && !eg1) wcnt_m = (wcnt_m < MW) ? wcnt_m + 1 : MW;
      else              wcnt_m = 0;
      cmd_en_m = eg0 | eg1;
      if (eg0 | eg1) begin
        cmd_we_m    = eg1 ? we1 : we0;
        cmd_addr_m  = 32'(eg1 ? addr1 : addr0);
        cmd_wdata_m = eg1 ? wdata1 : wdata0;
        a = int'(cmd_addr_m);
        if (cmd_we_m) begin
          mdl_mem[a] = cmd_wdata_m;
        end else begin
          d = mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
          ready_at = cyc + LAT + 2;
          rvq.push_back('{cyc + LAT + 2, eg1, d});
        end
      end
    end
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got;
    int wait_n;
    bit seen;
    bit any_rv;

    phys[5] = 32'h0000_1234;
    mdl_mem[5] = 32'h0000_1234;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check1("reset_mem_en", mem_en, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check32("reset_rdata0", rdata0, 32'h0);

    // single write
    next_cycle();
    req0 = 1; we0 = 1; addr0 = 12'h010; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    check1("t1_gnt0", gnt0, 1'b1);
    check1("t1_gnt1", gnt1, 1'b0);
    next_cycle();
    req0 = 0;
    @(negedge clk);
    check1("t1_mem_en", mem_en, 1'b1);
    check1("t1_mem_we", mem_we, 1'b1);
    check32("t1_mem_addr", 32'(mem_addr), 32'd16);
    check32("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check1("t1_rvalid0", rvalid0, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("t1_mem_en_off", mem_en, 1'b0);

    // read latency on port 1
    next_cycle();
    req1 = 1; we1 = 0; addr1 = 12'd5;
    @(negedge clk);
    check1("t2_gnt1", gnt1, 1'b1);
    next_cycle();
    req1 = 0;
    @(negedge clk);
    check1("t2_mem_en", mem_en, 1'b1);
    check1("t2_mem_we", mem_we, 1'b0);
    check32("t2_mem_addr", 32'(mem_addr), 32'd5);
    check1("t2_busy_n1", busy, 1'b1);
    check1("t2_rvalid_n1", rvalid1, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("t2_busy_n2", busy, 1'b1);
    check1("t2_rvalid_n2", rvalid1, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("t2_rvalid_n3", rvalid1, 1'b1);
    check32("t2_rdata_n3", rdata1, 32'h0000_1234);
    check1("t2_busy_n3", busy, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("t2_rvalid_n4", rvalid1, 1'b0);
    check32("t2_rdata_hold", rdata1, 32'h0000_1234);

    // contention: three back-to-back port-0 writes beat a waiting port-1 write
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req0 = 1; we0 = 1; addr0 = AW'(20 + k); wdata0 = 32'h3000 + 32'(k);
      req1 = 1; we1 = 1; addr1 = 12'd30; wdata1 = 32'h77;
      @(negedge clk);
      check1("t3_gnt0", gnt0, 1'b1);
      check1("t3_gnt1", gnt1, 1'b0);
    end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    check1("t3_gnt1_alone", gnt1, 1'b1);
    next_cycle();
    req1 = 0;

    // starvation guard: port 1 wins on the 5th contended cycle
    got = 0;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      req0 = 1; we0 = 1; addr0 = AW'(40 + ((k < 6) ? k : 5)); wdata0 = 32'h4000 + 32'(k);
      req1 = (got == 0); we1 = 1; addr1 = 12'd50; wdata1 = 32'h5555;
      @(negedge clk);
      if (gnt1 && got == 0) got = k;
      if (k == 5) check1("t4_gnt0_c5", gnt0, 1'b0);
      if (k == 6) check1("t4_gnt0_resume", gnt0, 1'b1);
    end
    check32("t4_gnt1_cycle", 32'(got), 32'd5);
    next_cycle();
    req0 = 0; req1 = 0;

    // request during read: port-1 write waits until rvalid0
    next_cycle();
    req0 = 1; we0 = 0; addr0 = 12'h010;
    @(negedge clk);
    check1("t5_gnt0", gnt0, 1'b1);
    next_cycle();
    req0 = 0; req1 = 1; we1 = 1; addr1 = 12'h010; wdata1 = 32'hCAFEF00D;
    seen = 0; wait_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (gnt1) begin
        seen = 1; wait_n = k;
        check1("t5_rvalid0_with_gnt1", rvalid0, 1'b1);
        check32("t5_rdata0", rdata0, 32'hDEADBEEF);
        break;
      end
      next_cycle();
    end
    check1("t5_gnt1_seen", seen, 1'b1);
    check32("t5_wait_cycles", 32'(wait_n), 32'd2);
    next_cycle();
    req1 = 0;

    // write then read of the same address on consecutive cycles
    next_cycle();
    req0 = 1; we0 = 1; addr0 = 12'd100; wdata0 = 32'h0000_CAFE;
    @(negedge clk);
    check1("t6_gnt_wr", gnt0, 1'b1);
    next_cycle();
    we0 = 0;
    @(negedge clk);
    check1("t6_gnt_rd", gnt0, 1'b1);
    next_cycle();
    req0 = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    check1("t6_rvalid0", rvalid0, 1'b1);
    check32("t6_rdata0", rdata0, 32'h0000_CAFE);

    // reset in the cycle after a read grant
    next_cycle();
    req1 = 1; we1 = 0; addr1 = 12'h010;
    @(negedge clk);
    check1("t7_gnt1", gnt1, 1'b1);
    next_cycle();
    req1 = 0; rst = 1;
    @(negedge clk);
    check1("t7_busy_rst", busy, 1'b0);
    check1("t7_mem_en_rst", mem_en, 1'b0);
    next_cycle();
    rst = 0;
    any_rv = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) any_rv = 1;
      next_cycle();
    end
    check1("t7_no_rvalid", any_rv, 1'b0);
    req0 = 1; we0 = 1; addr0 = 12'd7; wdata0 = 32'h1;
    @(negedge clk);
    check1("t7_gnt0_after", gnt0, 1'b1);
    next_cycle();
    req0 = 0;
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
